// File: rtl/pico_io_pkg.sv
// Shared constants for the pico I/O responder.
//   Register map (port_id):
//     ADDR_SW   0x00  debounced switch value (read only)
//     ADDR_CTRL 0x01  control, bit CTRL_IRQ_EN_BIT = irq_en (read/write)
//     ADDR_CHG  0x02  accumulated switch change bits (read, clear-on-read)
//     ADDR_LED  0x03  LED register (read/write)
//   Any other address reads 0x00 and ignores writes.
package pico_io_pkg;

  localparam logic [7:0] ADDR_SW   = 8'h00;
  localparam logic [7:0] ADDR_CTRL = 8'h01;
  localparam logic [7:0] ADDR_CHG  = 8'h02;
  localparam logic [7:0] ADDR_LED  = 8'h03;

  // CTRL bit positions; bits 7:1 are unimplemented and read 0.
  localparam int CTRL_IRQ_EN_BIT = 0;

endpackage

// File: rtl/pico_io_resp_if.sv
// Processor port bus between a PicoBlaze-style master and the I/O responder.
//   port_id       address, held for 2 cycles around each strobe
//   write_strobe  single-cycle write qualifier, out_port valid with it
//   read_strobe   single-cycle read qualifier
//   out_port      write data from the processor
//   in_port       registered read data (1-cycle latency from port_id)
//   interrupt     level interrupt request
//   interrupt_ack single-cycle acknowledge from the processor
//
// Handshake: there is no valid/ready backpressure on this bus. A strobe
// is the valid qualifier and the responder is always ready, so every
// strobe is consumed on the rising edge where it is high. Read data is
// not qualified; it is a registered copy of the mux selected by port_id,
// which lands inside the 2-cycle port_id window.
interface pico_io_resp_if;
  logic [7:0] port_id;
  logic       write_strobe;
  logic       read_strobe;
  logic [7:0] out_port;
  logic [7:0] in_port;
  logic       interrupt;
  logic       interrupt_ack;

  modport master (
    output port_id, write_strobe, read_strobe, out_port, interrupt_ack,
    input  in_port, interrupt
  );

  modport slave (
    input  port_id, write_strobe, read_strobe, out_port, interrupt_ack,
    output in_port, interrupt
  );
endinterface

// File: rtl/sw_debounce.sv
// Switch synchronizer and debouncer.
//   clk, reset  rising-edge clock, synchronous active-high reset
//   sw          asynchronous switch inputs
//   db          debounced switch value
//   chg_evt     one-cycle pulse, high in the cycle after db updates
//   chg_mask    old ^ new debounced value, valid while chg_evt is high
//                (zero otherwise)
// A synchronized value must differ from db for DB_CYCLES consecutive
// cycles before it is accepted; any return to db restarts the count.
module sw_debounce #(
  parameter int DB_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] sw,
  output logic [7:0] db,
  output logic       chg_evt,
  output logic [7:0] chg_mask
);

  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

  logic [7:0]    sync1;
  logic [7:0]    sync2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1    <= 8'h00;
      sync2    <= 8'h00;
      db       <= 8'h00;
      cnt      <= '0;
      chg_evt  <= 1'b0;
      chg_mask <= 8'h00;
    end else begin
      sync1    <= sw;
      sync2    <= sync1;
      chg_evt  <= 1'b0;
      chg_mask <= 8'h00;
      if (sync2 == db) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        db       <= sync2;
        cnt      <= '0;
        chg_evt  <= 1'b1;
        chg_mask <= db ^ sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/pico_io_resp.sv
// Pico I/O responder: switch input, LED output and change interrupt on a
// PicoBlaze-style port bus.
//   clk, reset  rising-edge clock, synchronous active-high reset
//   bus         pico_io_resp_if.slave (port_id, strobes, data, interrupt)
//   sw          asynchronous board switches
//   led         LED register output
// Optional feature: define PICO_IO_IRQ_EN to build the change interrupt.
// Without it interrupt is tied 0, interrupt_ack is ignored and CTRL bit0
// reads 0.
module pico_io_resp
  import pico_io_pkg::*;
#(
  parameter int DB_CYCLES = 50000
) (
  input  logic                 clk,
  input  logic                 reset,
  pico_io_resp_if.slave        bus,
  input  logic [7:0]           sw,
  output logic [7:0]           led
);

  logic [7:0] db;
  logic       chg_evt;
  logic [7:0] chg_mask;
  logic [7:0] led_q;
  logic [7:0] chg_q;
  logic [7:0] in_port_q;
  logic       irq_en;
  logic [7:0] ctrl_rd;
  logic [7:0] rd_mux;
  logic       wr_led;
  logic       wr_ctrl;
  logic       rd_chg;

  sw_debounce #(.DB_CYCLES(DB_CYCLES)) u_sw_debounce (
    .clk      (clk),
    .reset    (reset),
    .sw       (sw),
    .db       (db),
    .chg_evt  (chg_evt),
    .chg_mask (chg_mask)
  );

  assign wr_led  = bus.write_strobe && (bus.port_id == ADDR_LED);
  assign wr_ctrl = bus.write_strobe && (bus.port_id == ADDR_CTRL);
  assign rd_chg  = bus.read_strobe  && (bus.port_id == ADDR_CHG);

  always_ff @(posedge clk) begin
    if (reset) begin
      led_q <= 8'h00;
    end else if (wr_led) begin
      led_q <= bus.out_port;
    end
  end

  // Clear-on-read and new change bits in the same cycle: the clear drops
  // the old bits, the new bits are still set.
  always_ff @(posedge clk) begin
    if (reset) begin
      chg_q <= 8'h00;
    end else begin
      chg_q <= (rd_chg ? 8'h00 : chg_q) | (chg_evt ? chg_mask : 8'h00);
    end
  end

`ifdef PICO_IO_IRQ_EN
  logic irq_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      irq_en <= 1'b0;
    end else if (wr_ctrl) begin
      irq_en <= bus.out_port[CTRL_IRQ_EN_BIT];
    end
  end

  // Set wins over ack; irq_en only gates new requests, it never clears one.
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_q <= 1'b0;
    end else if (chg_evt && irq_en) begin
      irq_q <= 1'b1;
    end else if (bus.interrupt_ack) begin
      irq_q <= 1'b0;
    end
  end

  assign bus.interrupt = irq_q;
`else
  logic unused_irq_inputs;

  assign irq_en            = 1'b0;
  assign bus.interrupt     = 1'b0;
  assign unused_irq_inputs = bus.interrupt_ack ^ wr_ctrl;
`endif

  always_comb begin
    ctrl_rd                  = 8'h00;
    ctrl_rd[CTRL_IRQ_EN_BIT] = irq_en;
  end

  always_comb begin
    rd_mux = 8'h00;
    case (bus.port_id)
      ADDR_SW:   rd_mux = db;
      ADDR_CTRL: rd_mux = ctrl_rd;
      ADDR_CHG:  rd_mux = chg_q;
      ADDR_LED:  rd_mux = led_q;
      default:   rd_mux = 8'h00;
    endcase
  end

  // Registered every cycle, not only on read_strobe, so data is ready in
  // the second cycle of the port_id window.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_port_q <= 8'h00;
    end else begin
      in_port_q <= rd_mux;
    end
  end

  assign bus.in_port = in_port_q;
  assign led         = led_q;

endmodule

// File: tb/tb_pico_io_resp.sv
// Directed bench for pico_io_resp with DB_CYCLES=4. Read results go
// through an expected-value queue; direct output checks compare against
// constants. Interrupt expectations follow PICO_IO_IRQ_EN.
module tb_pico_io_resp;
  import pico_io_pkg::*;

`ifdef PICO_IO_IRQ_EN
  localparam logic IRQ_BUILT = 1'b1;
`else
  localparam logic IRQ_BUILT = 1'b0;
`endif

  logic       clk;
  logic       reset;
  logic [7:0] sw;
  logic [7:0] led;

  int checks;
  int errors;
  logic [7:0] exp_q[$];

  pico_io_resp_if bus ();

  pico_io_resp #(.DB_CYCLES(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .sw    (sw),
    .led   (led)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
    end
  endtask

  // driver tasks; all are entered and left on a falling edge
  task automatic do_write(input logic [7:0] addr, input logic [7:0] data);
    bus.port_id      = addr;
    bus.out_port     = data;
    bus.write_strobe = 1'b1;
    @(negedge clk);
    bus.write_strobe = 1'b0;
  endtask

  task automatic do_read(input logic [7:0] addr, input logic [7:0] exp, input string tag);
    bus.port_id     = addr;
    bus.read_strobe = 1'b1;
    exp_q.push_back(exp);
    @(negedge clk);
    bus.read_strobe = 1'b0;
    check(tag, bus.in_port, exp_q.pop_front());
  endtask

  task automatic ack_pulse();
    bus.interrupt_ack = 1'b1;
    @(negedge clk);
    bus.interrupt_ack = 1'b0;
  endtask

  initial begin
    checks            = 0;
    errors            = 0;
    reset             = 1'b1;
    sw                = 8'h00;
    bus.port_id       = 8'h00;
    bus.write_strobe  = 1'b0;
    bus.read_strobe   = 1'b0;
    bus.out_port      = 8'h00;
    bus.interrupt_ack = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // reset state
    check("rst_led", led, 8'h00);
    check("rst_in_port", bus.in_port, 8'h00);
    check("rst_irq", {7'b0, bus.interrupt}, 8'h00);
    do_read(ADDR_SW,   8'h00, "rst_sw");
    do_read(ADDR_CTRL, 8'h00, "rst_ctrl");
    do_read(ADDR_CHG,  8'h00, "rst_chg");
    do_read(ADDR_LED,  8'h00, "rst_ledreg");

    // two-cycle glitch must be rejected
    sw = 8'hFF;
    repeat (2) @(negedge clk);
    sw = 8'h00;
    repeat (10) @(negedge clk);
    do_read(ADDR_SW,  8'h00, "glitch_sw");
    do_read(ADDR_CHG, 8'h00, "glitch_chg");
    check("glitch_irq", {7'b0, bus.interrupt}, 8'h00);

    // stable change accepted, CHG clear-on-read
    sw = 8'hA5;
    repeat (10) @(negedge clk);
    do_read(ADDR_SW,  8'hA5, "a5_sw");
    do_read(ADDR_CHG, 8'hA5, "a5_chg");
    do_read(ADDR_CHG, 8'h00, "a5_chg_cleared");

    // LED register and unmapped address
    do_write(ADDR_LED, 8'h3C);
    check("led_write", led, 8'h3C);
    do_read(ADDR_LED, 8'h3C, "led_read");
    do_write(8'h07, 8'hFF);
    check("led_unmapped_write", led, 8'h3C);
    do_read(8'h07, 8'h00, "unmapped_read");
    do_write(ADDR_SW, 8'h77);
    do_read(ADDR_SW, 8'hA5, "sw_write_ignored");

    // change with irq disabled: no interrupt, CHG gets old^new
    do_write(ADDR_CTRL, 8'h00);
    sw = 8'h00;
    repeat (10) @(negedge clk);
    check("noirq_irq", {7'b0, bus.interrupt}, 8'h00);
    do_read(ADDR_CHG, 8'hA5, "a5_to_00_chg");

    // enable irq; CTRL readback depends on build
    do_write(ADDR_CTRL, 8'hFF);
    do_read(ADDR_CTRL, {7'b0, IRQ_BUILT}, "ctrl_read");

    // 0x00 -> 0x01 raises interrupt and holds it
    sw = 8'h01;
    repeat (10) @(negedge clk);
    check("irq_set", {7'b0, bus.interrupt}, {7'b0, IRQ_BUILT});
    repeat (3) @(negedge clk);
    check("irq_hold", {7'b0, bus.interrupt}, {7'b0, IRQ_BUILT});
    do_write(ADDR_CTRL, 8'h00);
    check("irq_en_clear_keeps", {7'b0, bus.interrupt}, {7'b0, IRQ_BUILT});
    ack_pulse();
    check("irq_acked", {7'b0, bus.interrupt}, 8'h00);
    do_write(ADDR_CTRL, 8'h01);

    // 0x01 -> 0x03: the update lands on the 6th rising edge after sw moves
    // (2 sync flops + 4 debounce cycles); the event is seen on the 7th,
    // where the CHG read strobe and the ack are placed.
    sw = 8'h03;
    repeat (6) @(negedge clk);
    bus.port_id       = ADDR_CHG;
    bus.read_strobe   = 1'b1;
    bus.interrupt_ack = 1'b1;
    exp_q.push_back(8'h01);
    @(negedge clk);
    bus.read_strobe   = 1'b0;
    bus.interrupt_ack = 1'b0;
    check("coinc_chg_old", bus.in_port, exp_q.pop_front());
    check("coinc_irq", {7'b0, bus.interrupt}, {7'b0, IRQ_BUILT});
    do_read(ADDR_CHG, 8'h02, "coinc_chg_new");
    do_read(ADDR_SW,  8'h03, "coinc_sw");
    check("coinc_irq_hold", {7'b0, bus.interrupt}, {7'b0, IRQ_BUILT});

    // reset mid-debounce, with a coincident LED write that must lose
    sw = 8'h00;
    repeat (3) @(negedge clk);
    reset            = 1'b1;
    bus.port_id      = ADDR_LED;
    bus.out_port     = 8'hFF;
    bus.write_strobe = 1'b1;
    @(negedge clk);
    bus.write_strobe = 1'b0;
    check("mid_rst_led", led, 8'h00);
    check("mid_rst_in_port", bus.in_port, 8'h00);
    check("mid_rst_irq", {7'b0, bus.interrupt}, 8'h00);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    check("post_rst_irq", {7'b0, bus.interrupt}, 8'h00);
    do_read(ADDR_CHG,  8'h00, "post_rst_chg");
    do_read(ADDR_SW,   8'h00, "post_rst_sw");
    do_read(ADDR_CTRL, 8'h00, "post_rst_ctrl");
    do_read(ADDR_LED,  8'h00, "post_rst_ledreg");

    check("queue_empty", 8'(exp_q.size()), 8'h00);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pico_io_resp.md
PICO_IO_RESP -- requirements
Module: pico_io_resp

Interface
REQ-001 SHALL have parameter DB_CYCLES, default 50000: number of consecutive clk cycles a synchronized switch value must differ from the debounced value before it is accepted.
REQ-002 SHALL have port clk  input  1: single clock; all logic on its rising edge.
REQ-003 SHALL have port reset  input  1: synchronous, active-high reset.
REQ-004 SHALL have port port_id  input  8: processor port address, held valid for 2 cycles around each strobe.
REQ-005 SHALL have port write_strobe  input  1: one-cycle write qualifier.
REQ-006 SHALL have port read_strobe  input  1: one-cycle read qualifier.
REQ-007 SHALL have port out_port  input  8: processor write data.
REQ-008 SHALL have port in_port  output  8: registered read data to the processor.
REQ-009 SHALL have port sw  input  8: asynchronous board switches.
REQ-010 SHALL have port led  output  8: LED register.
REQ-011 SHALL have port interrupt  output  1: level interrupt request to the processor.
REQ-012 SHALL have port interrupt_ack  input  1: one-cycle acknowledge from the processor.

Function
REQ-013 SHALL pass sw through a 2-flop synchronizer before any use.
REQ-014 SHALL debounce: the counter clears when sync equals debounced value; it increments while they differ; on reaching DB_CYCLES-1 with sync still different, the debounced value takes the sync value and the counter clears.
REQ-015 SHALL OR (old XOR new) into CHG and raise a one-cycle change event on every debounced update.
REQ-016 SHALL fully decode port_id: 0x00 SW (R), 0x01 CTRL (R/W, bit0 irq_en, bits 7:1 read 0), 0x02 CHG (R, clear-on-read), 0x03 LED (R/W); all other addresses read 0x00, and writes to them are ignored.
REQ-017 SHALL register in_port every cycle from the current port_id mux (1-cycle latency, inside the 2-cycle port_id window).
REQ-018 SHALL update LED/CTRL on the edge after write_strobe with matching port_id; writes to SW/CHG are ignored.
REQ-019 SHALL clear CHG on the edge after read_strobe with port_id 0x02; a change event in that same cycle leaves only the new bits set (set wins).
REQ-020 SHALL drive led directly from the LED register.

Reset
REQ-021 SHALL set on reset: led 0x00, in_port 0x00, CTRL 0x00, CHG 0x00, interrupt 0, debounced value 0x00, counter 0, synchronizer flops 0.
REQ-022 SHALL let reset override strobes and change events in the same cycle.

Configuration
REQ-023 SHALL, with macro PICO_IO_IRQ_EN defined, set interrupt on a change event while irq_en=1 and hold it until interrupt_ack; ack coincident with a new event leaves interrupt at 1; clearing irq_en does not drop a pending interrupt.
REQ-024 SHALL, without PICO_IO_IRQ_EN, tie interrupt to 0, ignore interrupt_ack, and make CTRL bit0 non-writable so it reads 0.

Structure
REQ-025 SHALL place register address constants (0x00-0x03) and CTRL bit positions in shared package pico_io_pkg.
REQ-026 SHALL implement the synchronizer and debounce counter in sub-module sw_debounce (parameter DB_CYCLES; outputs db value and change-event pulse).

Verification (bench DB_CYCLES=4)
REQ-027 SHALL cover: sw 0x00->0xA5 held 10 cycles -> read 0x00 returns 0xA5, read 0x02 returns 0xA5, next read 0x02 returns 0x00.
REQ-028 SHALL cover: sw glitch to 0xFF for 2 cycles -> SW stays 0x00, CHG stays 0x00, interrupt stays 0.
REQ-029 SHALL cover: write 0x3C to 0x03 -> led=0x3C on next edge; read 0x03 returns 0x3C; write to 0x07 leaves led=0x3C and read 0x07 returns 0x00.
REQ-030 SHALL cover (PICO_IO_IRQ_EN): write 0x01 to 0x01, sw 0x00->0x01 -> interrupt=1 until interrupt_ack pulse; ack coinciding with sw 0x01->0x03 debounced update -> interrupt stays 1.
REQ-031 SHALL cover: CHG read strobe in the same cycle as debounced update 0x01->0x03 -> CHG afterwards reads 0x02.
REQ-032 SHALL cover: reset asserted mid-debounce with led=0x3C -> all outputs 0 next edge; no spurious change event after reset release with sw=0x00.
